// File: rtl/fetch_pkg.sv
// Shared types, constants and address helpers for the fetch stage.
package fetch_pkg;

    localparam int unsigned PC_W     = 32;
    localparam int unsigned OFFSET_W = 16;
    localparam int unsigned TARGET_W = 26;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        HALT  = 2'd2,
        FAULT = 2'd3
    } state_t;

    localparam logic [PC_W-1:0] PC_STEP          = 32'd4;
    localparam logic [PC_W-1:0] JUMP_REGION_MASK = 32'hF000_0000;

    // J-type target keeps the 256 MB region of the sequential successor
    function automatic logic [PC_W-1:0] jump_addr(input logic [PC_W-1:0] pc_plus4,
                                                  input logic [TARGET_W-1:0] target);
        return (pc_plus4 & JUMP_REGION_MASK) | {4'b0000, target, 2'b00};
    endfunction

    function automatic logic [PC_W-1:0] branch_addr(input logic [PC_W-1:0] pc_plus4,
                                                    input logic [OFFSET_W-1:0] offset);
        return pc_plus4 + {{(PC_W-OFFSET_W-2){offset[OFFSET_W-1]}}, offset, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_if.sv
// Request/status bundle between the fetch stage and the rest of the core.
interface fetch_if;
    import fetch_pkg::*;

    logic                stall;
    logic                halt;
    logic                branch_taken;
    logic [OFFSET_W-1:0] branch_offset;
    logic                jump;
    logic [TARGET_W-1:0] jump_target;
    logic [PC_W-1:0]     pc;
    logic [PC_W-1:0]     pc_plus4;
    logic                fetch_valid;
    logic                halted;
    logic                fault;
    logic [PC_W-1:0]     instr_count;

    modport master (
        output stall, halt, branch_taken, branch_offset, jump, jump_target,
        input  pc, pc_plus4, fetch_valid, halted, fault, instr_count
    );

    modport slave (
        input  stall, halt, branch_taken, branch_offset, jump, jump_target,
        output pc, pc_plus4, fetch_valid, halted, fault, instr_count
    );

endinterface

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection (jump over branch over sequential) and range check.
module next_pc_calc
    import fetch_pkg::*;
#(
    parameter int unsigned IMEM_WORDS = 256
) (
    input  logic [PC_W-1:0]     pc,
    input  logic [OFFSET_W-1:0] branch_offset,
    input  logic [TARGET_W-1:0] jump_target,
    input  logic                branch_taken,
    input  logic                jump,
    output logic [PC_W-1:0]     pc_plus4,
    output logic [PC_W-1:0]     next_pc,
    output logic                out_of_range
);

    // One bit wider so a 4 GB memory limit does not wrap to zero
    localparam logic [PC_W:0] PC_LIMIT = 33'(IMEM_WORDS) * 33'd4;

    always_comb begin
        pc_plus4 = pc + PC_STEP;
        next_pc  = pc_plus4;
        if (jump) begin
            next_pc = jump_addr(pc_plus4, jump_target);
        end else if (branch_taken) begin
            next_pc = branch_addr(pc_plus4, branch_offset);
        end
        out_of_range = ({1'b0, next_pc} >= PC_LIMIT);
    end

endmodule

// File: rtl/fetch_unit.sv
// PC register, boot/run/halt/fault sequencing and committed-instruction counter.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_WORDS = 256
) (
    input  logic    clk,
    input  logic    reset,
    fetch_if.slave  bus
);

    localparam logic [PC_W-1:0] BOOT_PC = {RESET_PC[PC_W-1:2], 2'b00};

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] count_q, count_d;
    logic            fetch_valid_q, halted_q, fault_q;
    logic [PC_W-1:0] pc_plus4, next_pc;
    logic            out_of_range;

    next_pc_calc #(
        .IMEM_WORDS (IMEM_WORDS)
    ) u_next_pc_calc (
        .pc            (pc_q),
        .branch_offset (bus.branch_offset),
        .jump_target   (bus.jump_target),
        .branch_taken  (bus.branch_taken),
        .jump          (bus.jump),
        .pc_plus4      (pc_plus4),
        .next_pc       (next_pc),
        .out_of_range  (out_of_range)
    );

    // State, PC and counter registers; status flags follow the next state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= BOOT;
            pc_q          <= BOOT_PC;
            count_q       <= '0;
            fetch_valid_q <= 1'b0;
            halted_q      <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            count_q       <= count_d;
            fetch_valid_q <= (state_d == RUN);
            halted_q      <= (state_d == HALT);
            fault_q       <= (state_d == FAULT);
        end
    end

    // Stall outranks halt; an illegal target still commits the current instruction
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        count_d = count_q;
        case (state_q)
            BOOT: begin
                state_d = RUN;
                pc_d    = BOOT_PC;
            end
            RUN: begin
                if (!bus.stall) begin
                    if (bus.halt) begin
                        state_d = HALT;
                    end else begin
                        count_d = count_q + 32'd1;
                        if (out_of_range) begin
                            state_d = FAULT;
                        end else begin
                            pc_d = next_pc;
                        end
                    end
                end
            end
            HALT:    state_d = HALT;
            FAULT:   state_d = FAULT;
            default: state_d = BOOT;
        endcase
    end

    assign bus.pc          = pc_q;
    assign bus.pc_plus4    = pc_plus4;
    assign bus.fetch_valid = fetch_valid_q;
    assign bus.halted      = halted_q;
    assign bus.fault       = fault_q;
    assign bus.instr_count = count_q;

endmodule
